// File: rtl/tm1638_pkg.sv
// Shared constants, state encodings and the hex-to-segment table for the TM1638 controller.
package tm1638_pkg;

   localparam logic [7:0] CMD_DATA_WRITE_AI = 8'h40;
   localparam logic [7:0] CMD_ADDR_BASE     = 8'hC0;
   localparam logic [7:0] CMD_DISP_CTRL     = 8'h80;

   typedef enum logic [2:0] {
      S_IDLE, S_CMD1, S_GAP1, S_ADDR, S_DATA, S_GAP2, S_CMD3, S_FIN
   } state_t;

   // Sub-step inside a strobed group: setup half period, shifting bytes, hold half period.
   typedef enum logic [1:0] {
      PH_SETUP, PH_SHIFT, PH_HOLD
   } phase_t;

   // Common-cathode pattern, bit0=a .. bit6=g, dp off.
   function automatic logic [7:0] seg7_encode(input logic [3:0] hex);
      logic [7:0] seg;
      case (hex)
         4'h0: seg = 8'h3F;
         4'h1: seg = 8'h06;
         4'h2: seg = 8'h5B;
         4'h3: seg = 8'h4F;
         4'h4: seg = 8'h66;
         4'h5: seg = 8'h6D;
         4'h6: seg = 8'h7D;
         4'h7: seg = 8'h07;
         4'h8: seg = 8'h7F;
         4'h9: seg = 8'h6F;
         4'hA: seg = 8'h77;
         4'hB: seg = 8'h7C;
         4'hC: seg = 8'h39;
         4'hD: seg = 8'h5E;
         4'hE: seg = 8'h79;
         default: seg = 8'h71;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/tm1638_byte_shifter.sv
// Shifts one byte LSB first: each bit is CLK_DIV cycles with sclk low, then CLK_DIV with sclk high.
module tm1638_byte_shifter #(
   parameter int CLK_DIV = 25
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [7:0] byte_in,
   output logic       ready,
   output logic       sclk,
   output logic       sdio
);

   localparam int HW = $clog2(CLK_DIV);
   localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);

   logic          active_reg;
   logic          low_reg;
   logic [2:0]    bit_cnt_reg;
   logic [HW-1:0] half_cnt_reg;
   logic [7:0]    shift_reg;
   logic          half_end;

   assign half_end = (half_cnt_reg == HALF_LAST);
   // Ready in the last cycle of the final high half so back-to-back bytes have no extra clock cycle.
   assign ready = !active_reg || (!low_reg && half_end && bit_cnt_reg == 3'd7);
   assign sclk  = !(active_reg && low_reg);
   assign sdio  = active_reg ? shift_reg[0] : 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_reg   <= 1'b0;
         low_reg      <= 1'b0;
         bit_cnt_reg  <= '0;
         half_cnt_reg <= '0;
         shift_reg    <= 8'hFF;
      end else if (load && ready) begin
         active_reg   <= 1'b1;
         low_reg      <= 1'b1;
         bit_cnt_reg  <= '0;
         half_cnt_reg <= '0;
         shift_reg    <= byte_in;
      end else if (active_reg) begin
         if (half_end) begin
            half_cnt_reg <= '0;
            if (low_reg) begin
               low_reg <= 1'b0;
            end else if (bit_cnt_reg == 3'd7) begin
               active_reg <= 1'b0;
            end else begin
               low_reg     <= 1'b1;
               bit_cnt_reg <= bit_cnt_reg + 3'd1;
               shift_reg   <= {1'b1, shift_reg[7:1]};
            end
         end else begin
            half_cnt_reg <= half_cnt_reg + 1'b1;
         end
      end
   end

endmodule

// File: rtl/tm1638_frame_sequencer.sv
// Latches eight hex digits and sends the full TM1638 write frame (0x40 / 0xC0+16 bytes / 0x8x).
// Define TM1638_LED_EN to add the leds port driving the discrete LED bytes.
module tm1638_frame_sequencer #(
   parameter int CLK_DIV    = 25,
   parameter int GAP_HALVES = 2
) (
   input  logic        _50MHz_CLK,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] digits,
   input  logic [2:0]  brightness,
   input  logic        display_on,
`ifdef TM1638_LED_EN
   input  logic [7:0]  leds,
`endif
   output logic        busy,
   output logic        done,
   output logic        clk,
   output logic        stb,
   output logic        dio
);

   import tm1638_pkg::*;

   localparam int HW = $clog2(CLK_DIV);
   localparam int GW = (GAP_HALVES > 1) ? $clog2(GAP_HALVES) : 1;
   localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_HALVES - 1);

   state_t        state_reg, state_next;
   phase_t        phase_reg, phase_next;
   logic [HW-1:0] half_cnt_reg, half_cnt_next;
   logic [GW-1:0] gap_cnt_reg, gap_cnt_next;
   logic [3:0]    byte_idx_reg, byte_idx_next;
   logic [31:0]   digits_reg;
   logic [2:0]    brightness_reg;
   logic          display_on_reg;
   logic          accept, in_group, half_end, last_byte;
   logic          load, sh_ready;
   logic [7:0]    load_byte, ctrl_byte;
   logic [7:0]    data_bytes [16];

   assign half_end  = (half_cnt_reg == HALF_LAST);
   assign last_byte = (byte_idx_reg == 4'd15);
   assign in_group  = (state_reg == S_CMD1) || (state_reg == S_ADDR) ||
                      (state_reg == S_DATA) || (state_reg == S_CMD3);
   assign ctrl_byte = CMD_DISP_CTRL | {4'b0000, display_on_reg, brightness_reg};

`ifdef TM1638_LED_EN
   logic [7:0] leds_reg;
`endif

   // Even bytes carry the grid segments, odd bytes the LED above that grid.
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_bytes
         assign data_bytes[2*gi] = seg7_encode(digits_reg[4*gi +: 4]);
`ifdef TM1638_LED_EN
         assign data_bytes[2*gi+1] = {7'b0, leds_reg[gi]};
`else
         assign data_bytes[2*gi+1] = 8'h00;
`endif
      end
   endgenerate

   always_ff @(posedge _50MHz_CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= S_IDLE;
         phase_reg    <= PH_SETUP;
         half_cnt_reg <= '0;
         gap_cnt_reg  <= '0;
         byte_idx_reg <= '0;
      end else begin
         state_reg    <= state_next;
         phase_reg    <= phase_next;
         half_cnt_reg <= half_cnt_next;
         gap_cnt_reg  <= gap_cnt_next;
         byte_idx_reg <= byte_idx_next;
      end
   end

   always_ff @(posedge _50MHz_CLK or negedge rst_n) begin
      if (!rst_n) begin
         digits_reg     <= '0;
         brightness_reg <= '0;
         display_on_reg <= 1'b0;
`ifdef TM1638_LED_EN
         leds_reg       <= '0;
`endif
      end else if (accept) begin
         digits_reg     <= digits;
         brightness_reg <= brightness;
         display_on_reg <= display_on;
`ifdef TM1638_LED_EN
         leds_reg       <= leds;
`endif
      end
   end

   always_comb begin
      state_next    = state_reg;
      phase_next    = phase_reg;
      half_cnt_next = half_cnt_reg;
      gap_cnt_next  = gap_cnt_reg;
      byte_idx_next = byte_idx_reg;
      accept        = 1'b0;
      case (state_reg)
         S_IDLE, S_FIN: begin
            state_next = S_IDLE;
            if (start) begin
               accept        = 1'b1;
               state_next    = S_CMD1;
               phase_next    = PH_SETUP;
               half_cnt_next = '0;
            end
         end
         S_GAP1, S_GAP2: begin
            if (half_end) begin
               half_cnt_next = '0;
               if (gap_cnt_reg == GAP_LAST) begin
                  gap_cnt_next = '0;
                  state_next   = (state_reg == S_GAP1) ? S_ADDR : S_CMD3;
                  phase_next   = PH_SETUP;
               end else begin
                  gap_cnt_next = gap_cnt_reg + 1'b1;
               end
            end else begin
               half_cnt_next = half_cnt_reg + 1'b1;
            end
         end
         default: begin
            case (phase_reg)
               PH_SETUP: begin
                  if (half_end) begin
                     half_cnt_next = '0;
                     phase_next    = PH_SHIFT;
                  end else begin
                     half_cnt_next = half_cnt_reg + 1'b1;
                  end
               end
               PH_SHIFT: begin
                  if (sh_ready) begin
                     if (state_reg == S_ADDR) begin
                        state_next    = S_DATA;
                        byte_idx_next = '0;
                     end else if (state_reg == S_DATA && !last_byte) begin
                        byte_idx_next = byte_idx_reg + 4'd1;
                     end else begin
                        phase_next = PH_HOLD;
                     end
                  end
               end
               default: begin
                  if (half_end) begin
                     half_cnt_next = '0;
                     phase_next    = PH_SETUP;
                     state_next    = (state_reg == S_CMD1) ? S_GAP1 :
                                     (state_reg == S_DATA) ? S_GAP2 : S_FIN;
                  end else begin
                     half_cnt_next = half_cnt_reg + 1'b1;
                  end
               end
            endcase
         end
      endcase
   end

   always_comb begin
      stb       = !in_group;
      busy      = (state_reg != S_IDLE) && (state_reg != S_FIN);
      done      = (state_reg == S_FIN);
      load      = 1'b0;
      load_byte = 8'hFF;
      if (in_group) begin
         if (phase_reg == PH_SETUP && half_end) begin
            load = 1'b1;
            case (state_reg)
               S_CMD1:  load_byte = CMD_DATA_WRITE_AI;
               S_ADDR:  load_byte = CMD_ADDR_BASE;
               default: load_byte = ctrl_byte;
            endcase
         end else if (phase_reg == PH_SHIFT && sh_ready) begin
            if (state_reg == S_ADDR) begin
               load      = 1'b1;
               load_byte = data_bytes[0];
            end else if (state_reg == S_DATA && !last_byte) begin
               load      = 1'b1;
               load_byte = data_bytes[byte_idx_reg + 4'd1];
            end
         end
      end
   end

   tm1638_byte_shifter #(
      .CLK_DIV(CLK_DIV)
   ) u_shifter (
      .clk     (_50MHz_CLK),
      .rst_n   (rst_n),
      .load    (load),
      .byte_in (load_byte),
      .ready   (sh_ready),
      .sclk    (clk),
      .sdio    (dio)
   );

endmodule

// File: tb/tb_tm1638_frame_sequencer.sv
// Bench for tm1638_frame_sequencer: decodes the serial pins into bytes and checks whole frames.
module tb_tm1638_frame_sequencer;

   localparam int CLK_DIV    = 4;
   localparam int GAP_HALVES = 2;

   logic        sys_clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] digits = '0;
   logic [2:0]  brightness = '0;
   logic        display_on = 1'b0;
`ifdef TM1638_LED_EN
   logic [7:0]  leds = '0;
`endif
   logic        busy, done, tm_clk, stb, dio;

   always #5 sys_clk = ~sys_clk;

   tm1638_frame_sequencer #(
      .CLK_DIV(CLK_DIV),
      .GAP_HALVES(GAP_HALVES)
   ) dut (
      ._50MHz_CLK (sys_clk),
      .rst_n      (rst_n),
      .start      (start),
      .digits     (digits),
      .brightness (brightness),
      .display_on (display_on),
`ifdef TM1638_LED_EN
      .leds       (leds),
`endif
      .busy       (busy),
      .done       (done),
      .clk        (tm_clk),
      .stb        (stb),
      .dio        (dio)
   );

   typedef struct packed {
      logic [31:0]     digits;
      logic [2:0]      bright;
      logic            dispon;
      logic [7:0]      leds;
      logic [7:0][7:0] exp_seg;
      logic [7:0][7:0] exp_led;
      logic [7:0]      exp_ctrl;
   } vec_t;

   vec_t vecs [3];
   int   n_cmp = 0;
   int   n_bad = 0;

   int   cap_q [$];
   int   grp_len [$];
   int   done_cnt = 0;
   int   bad_bits = 0;

   // Pin monitor: a byte is assembled from dio at each clk rise while stb is low.
   initial begin
      logic       prev_clk, prev_stb, in_grp;
      int         bit_n, grp_bytes;
      logic [7:0] sh;
      prev_clk = 1'b1; prev_stb = 1'b1; in_grp = 1'b0;
      bit_n = 0; grp_bytes = 0; sh = '0;
      forever begin
         @(negedge sys_clk);
         if (!rst_n) begin
            in_grp = 1'b0; prev_clk = 1'b1; prev_stb = 1'b1;
         end else begin
            if (prev_stb && !stb) begin
               in_grp = 1'b1; bit_n = 0; grp_bytes = 0;
            end
            if (in_grp && !stb && !prev_clk && tm_clk) begin
               sh = {dio, sh[7:1]};
               bit_n++;
               if (bit_n == 8) begin
                  cap_q.push_back(int'(sh));
                  grp_bytes++;
                  bit_n = 0;
               end
            end
            if (in_grp && stb && !prev_stb) begin
               in_grp = 1'b0;
               grp_len.push_back(grp_bytes);
               if (bit_n != 0) bad_bits++;
            end
            if (done) done_cnt++;
            prev_clk = tm_clk;
            prev_stb = stb;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got time limit reached, expected run to finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] d, input logic [2:0] b, input logic on,
                               input logic [7:0] l, input logic [63:0] segs,
                               input logic [63:0] ledb, input logic [7:0] ctrl);
      vec_t m;
      m.digits = d; m.bright = b; m.dispon = on; m.leds = l;
      m.exp_seg = segs; m.exp_led = ledb; m.exp_ctrl = ctrl;
      return m;
   endfunction

   task automatic clear_cap();
      cap_q.delete();
      grp_len.delete();
      done_cnt = 0;
      bad_bits = 0;
   endtask

   task automatic apply_inputs(input vec_t v);
      digits = v.digits;
      brightness = v.bright;
      display_on = v.dispon;
`ifdef TM1638_LED_EN
      leds = v.leds;
`endif
   endtask

   task automatic wait_done(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 5000 && !seen; i++) begin
         @(posedge sys_clk); #1;
         if (done) seen = 1'b1;
      end
   endtask

   task automatic check_frame(input vec_t v, input string nm);
      int exp_b [19];
      int act;
      exp_b[0] = 8'h40;
      exp_b[1] = 8'hC0;
      for (int k = 0; k < 8; k++) begin
         exp_b[2+2*k] = int'(v.exp_seg[k]);
`ifdef TM1638_LED_EN
         exp_b[3+2*k] = int'(v.exp_led[k]);
`else
         exp_b[3+2*k] = 0;
`endif
      end
      exp_b[18] = int'(v.exp_ctrl);
      chk({nm, " groups"}, grp_len.size(), 3);
      chk({nm, " grp0_len"}, (grp_len.size() > 0) ? grp_len[0] : -1, 1);
      chk({nm, " grp1_len"}, (grp_len.size() > 1) ? grp_len[1] : -1, 17);
      chk({nm, " grp2_len"}, (grp_len.size() > 2) ? grp_len[2] : -1, 1);
      for (int i = 0; i < 19; i++) begin
         act = (i < cap_q.size()) ? cap_q[i] : -1;
         chk($sformatf("%s byte%0d", nm, i), act, exp_b[i]);
      end
      chk({nm, " partial_bits"}, bad_bits, 0);
   endtask

   task automatic run_frame(input vec_t v, input string nm);
      bit seen;
      clear_cap();
      apply_inputs(v);
      start = 1'b1;
      @(posedge sys_clk); #1;
      start = 1'b0;
      chk({nm, " busy_rise"}, int'(busy), 1);
      wait_done(seen);
      chk({nm, " done_seen"}, int'(seen), 1);
      chk({nm, " busy_at_done"}, int'(busy), 0);
      @(posedge sys_clk); #1;
      chk({nm, " done_width"}, int'(done), 0);
      check_frame(v, nm);
      chk({nm, " done_count"}, done_cnt, 1);
   endtask

   initial begin
      bit seen;
      int bad_idle;
      int stb_low;

      vecs[0] = mk(32'h76543210, 3'd7, 1'b1, 8'hA5,
                   64'h077D6D664F5B063F, 64'h0100010000010001, 8'h8F);
      vecs[1] = mk(32'hFEDCBA98, 3'd2, 1'b0, 8'h00,
                   64'h71795E397C776F7F, 64'h0000000000000000, 8'h82);
      vecs[2] = mk(32'h0A1B2C3D, 3'd0, 1'b1, 8'h3C,
                   64'h3F77067C5B394F5E, 64'h0000010101010000, 8'h88);

      repeat (3) @(posedge sys_clk);
      #1;
      chk("reset clk", int'(tm_clk), 1);
      chk("reset stb", int'(stb), 1);
      chk("reset dio", int'(dio), 1);
      chk("reset busy", int'(busy), 0);
      chk("reset done", int'(done), 0);
      rst_n = 1'b1;

      bad_idle = 0;
      for (int i = 0; i < 1000; i++) begin
         @(posedge sys_clk); #1;
         if (!(tm_clk && stb && dio && !busy && !done)) bad_idle++;
      end
      chk("idle_hold bad_cycles", bad_idle, 0);

      for (int v = 0; v < 3; v++) run_frame(vecs[v], $sformatf("vec%0d", v));

      // Second start during DATA with new digits must be ignored.
      clear_cap();
      apply_inputs(vecs[0]);
      start = 1'b1;
      @(posedge sys_clk); #1;
      start = 1'b0;
      repeat (400) @(posedge sys_clk);
      #1;
      apply_inputs(vecs[1]);
      start = 1'b1;
      @(posedge sys_clk); #1;
      start = 1'b0;
      chk("busy_ign busy", int'(busy), 1);
      wait_done(seen);
      chk("busy_ign done_seen", int'(seen), 1);
      @(posedge sys_clk); #1;
      check_frame(vecs[0], "busy_ign");
      stb_low = 0;
      for (int i = 0; i < 300; i++) begin
         @(posedge sys_clk); #1;
         if (!stb || busy) stb_low++;
      end
      chk("busy_ign quiet_after", stb_low, 0);
      chk("busy_ign done_count", done_cnt, 1);

      // Reset in the middle of DATA byte 5.
      clear_cap();
      apply_inputs(vecs[1]);
      start = 1'b1;
      @(posedge sys_clk); #1;
      start = 1'b0;
      repeat (500) @(posedge sys_clk);
      #1;
      chk("midrst in_data", int'(cap_q.size() >= 3 && busy), 1);
      rst_n = 1'b0;
      #1;
      chk("midrst clk", int'(tm_clk), 1);
      chk("midrst stb", int'(stb), 1);
      chk("midrst dio", int'(dio), 1);
      chk("midrst busy", int'(busy), 0);
      chk("midrst done", int'(done), 0);
      repeat (3) @(posedge sys_clk);
      #1;
      rst_n = 1'b1;
      @(posedge sys_clk); #1;
      chk("midrst no_done", done_cnt, 0);
      chk("midrst idle stb", int'(stb), 1);
      run_frame(vecs[2], "after_rst");

      // Start presented in the same cycle as done.
      clear_cap();
      apply_inputs(vecs[1]);
      start = 1'b1;
      @(posedge sys_clk); #1;
      start = 1'b0;
      wait_done(seen);
      chk("b2b first done_seen", int'(seen), 1);
      apply_inputs(vecs[2]);
      start = 1'b1;
      @(posedge sys_clk); #1;
      start = 1'b0;
      chk("b2b busy_rise", int'(busy), 1);
      check_frame(vecs[1], "b2b_first");
      chk("b2b_first done_count", done_cnt, 1);
      clear_cap();
      wait_done(seen);
      chk("b2b second done_seen", int'(seen), 1);
      @(posedge sys_clk); #1;
      check_frame(vecs[2], "b2b_second");
      chk("b2b_second done_count", done_cnt, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/tm1638_frame_sequencer.md
Name: tm1638_frame_sequencer

Overview:
- Controller for the TM1638 8-digit 7-segment board (serial clk/stb/dio).
- Latches eight 4-bit digit codes and encodes them to segment patterns.
- Sequences the full TM1638 write frame (data command, address plus 16 data bytes, display control) as an LSB-first bit-banged stream.
- Sits between the digit-producing logic and the board pins, replacing ad-hoc per-byte driving.

Parameters:
- CLK_DIV, 25: system cycles per half bit period. Default gives 1 MHz bit clock from 50 MHz. Legal range ≥2.
- GAP_HALVES, 2: stb-high time between command groups, in half bit periods.

Ports:
- _50MHz_CLK  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle request to send one frame
- digits  input  32  digit i = digits[4i+3:4i], hex code 0..F; i=0 is the leftmost grid
- brightness  input  3  TM1638 pulse-width setting
- display_on  input  1  display enable bit of the control command
- busy  output  1  frame in progress
- done  output  1  one-cycle pulse after the final stb rise
- clk  output  1  TM1638 bit clock, idle high
- stb  output  1  TM1638 strobe, idle high
- dio  output  1  TM1638 data, idle high, write-only

Behaviour:
- Reset values (asynchronous): clk=1, stb=1, dio=1, busy=0, done=0, FSM=IDLE, all counters 0.
- Start handling:
  - start in IDLE latches digits, brightness and display_on; busy rises next cycle.
  - start while busy is ignored.
  - start in the same cycle as done is accepted.
- FSM states: IDLE -> CMD1 -> GAP1 -> ADDR -> DATA -> GAP2 -> CMD3 -> FIN -> IDLE.
  - CMD1 sends 0x40 (write, auto-increment).
  - ADDR sends 0xC0.
  - DATA sends 16 bytes: seg(digit0), led0, seg(digit1), led1, … seg(digit7), led7.
  - CMD3 sends 0x80 | display_on<<3 | brightness.
  - FIN pulses done for one cycle, drops busy, returns to IDLE.
- Stb grouping:
  - stb is low across CMD1; low continuously across ADDR+DATA (17 bytes, no gaps); low across CMD3.
  - GAP1 and GAP2 hold stb=1, clk=1 for GAP_HALVES*CLK_DIV cycles.
- Byte timing:
  - stb falls, then one half period of setup with clk=1.
  - Per bit, LSB first: clk=0 and dio=bit for CLK_DIV cycles, then clk=1 for CLK_DIV cycles. The device samples on the clk rising edge.
  - After the last bit of a group: one half period with clk=1, then stb rises; dio returns to 1.
- Segment encoding:
  - bit0=a … bit6=g, bit7=dp=0, common cathode.
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F, A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71.
- Frame length: 19 bytes = 152 bit periods, plus setup/hold and gaps.
- Counters: half-period counter wraps at CLK_DIV-1; bit counter 0..7; byte index 0..15, width-checked with no overflow.
- Reset mid-frame: outputs return to idle immediately; no partial frame resumes; done is not pulsed.

Optional Feature:
- TM1638_LED_EN defined:
  - adds input port leds[7:0]; led byte i = {7'b0, leds[i]}, latched at start.
  - lights the discrete LED above grid i.
- Undefined: no leds port; all led bytes are 0x00.

Decomposition:
- Package tm1638_pkg:
  - command constants CMD_DATA_WRITE_AI=0x40, CMD_ADDR_BASE=0xC0, CMD_DISP_CTRL=0x80;
  - state enum;
  - seg7_encode function (hex to segment byte).
- Sub-module tm1638_byte_shifter:
  - load/byte/ready handshake;
  - generates clk/dio for 8 bits with the CLK_DIV timing.
  - The sequencer owns stb and the byte order.

Test Plan:
- Reset then idle, CLK_DIV=4: clk=stb=dio=1, busy=0 held for 1000 cycles with no start.
- Digit encoding: digits=0x76543210, brightness=7, display_on=1, start. Bench decodes bytes on clk rising edges while stb=0 and must see:
  - group 1: [0x40];
  - group 2: [0xC0,0x3F,00,0x06,00,0x5B,00,0x4F,00,0x66,00,0x6D,00,0x7D,00,0x07,00];
  - group 3: [0x8F].
  - done pulses exactly once.
- Hex digits: digits=0xFEDCBA98, display_on=0, brightness=2 -> seg bytes 0x7F,0x6F,0x77,0x7C,0x39,0x5E,0x79,0x71; control byte 0x82.
- Start while busy: second start mid-DATA is ignored. Exactly one frame is sent, and digits changed mid-frame do not appear.
- Reset mid-frame: assert rst_n=0 during byte 5 of DATA -> same-cycle clk=stb=dio=1, busy=0, no done. A fresh start afterwards yields a complete correct frame.
- TM1638_LED_EN defined, leds=0xA5 -> led bytes 0x01,00,0x01,00,00,0x01,00,0x01.
